// File: rtl/fpga_cfg_pkg.sv
// Shared types and sizing helpers for the configuration scan-chain loader.
package fpga_cfg_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_CLB  = 2'd1,
        LOAD_CONN = 2'd2,
        DONE      = 2'd3
    } state_e;

    // Bit-counter width: wide enough to hold the longer chain length exactly.
    function automatic int CNT_W(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/fpga_cfg_loader_scan_clk_gen.sv
// Scan clock divider: toggles scan_clk every CLK_DIV cycles while run_i is
// high and flags the cycle before each rising / falling transition.
module scan_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic run_i,
    output logic scan_clk_o,
    output logic rise_next_o,
    output logic fall_next_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q;
    logic          sclk_q;
    logic          term;

    assign term        = (div_q == DW'(CLK_DIV - 1));
    assign rise_next_o = run_i & term & ~sclk_q;
    assign fall_next_o = run_i & term &  sclk_q;
    assign scan_clk_o  = sclk_q;

    // Divider and scan clock register; an idle run restarts the low phase count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (clr_i) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (run_i) begin
            if (term) begin
                div_q  <= '0;
                sclk_q <= ~sclk_q;
            end else begin
                div_q  <= div_q + DW'(1);
            end
        end else begin
            div_q <= '0;
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Loads the CLB chain then the connection chain from a byte stream, LSB
// first, and returns the displaced chain bits as readback bytes.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CLB_BITS  = 4096,
    parameter int CONN_BITS = 2048,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       scan_clk,
    output logic       clb_scan_en,
    output logic       clb_scan_in,
    input  logic       clb_scan_out,
    output logic       conn_scan_en,
    output logic       conn_scan_in,
    input  logic       conn_scan_out,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done
);

    localparam int CW = CNT_W(CLB_BITS, CONN_BITS);

    state_e            state_q;
    logic [BYTE_W-1:0] buf_q;
    logic [3:0]        buf_cnt_q;
    logic [CW-1:0]     bit_cnt_q;
    logic [BYTE_W-1:0] rd_sh_q, rd_sh_d;
    logic [2:0]        rd_cnt_q;
    logic [BYTE_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              captured_q;

    logic          in_load, accept, shift, last_bit, sample, run, clr;
    logic          rise_next, fall_next;
    logic [3:0]    buf_fill_d;
    logic [CW-1:0] phase_last;

    assign in_load    = (state_q == LOAD_CLB) || (state_q == LOAD_CONN);
    assign cfg_ready  = in_load && (buf_cnt_q == 4'd0);
    assign accept     = cfg_valid & cfg_ready & ~abort;
    assign run        = in_load && (buf_cnt_q != 4'd0) && !abort;
    assign clr        = !in_load || abort;
    // Only advance once the fabric has actually seen this bit's rising edge.
    assign shift      = fall_next & captured_q & ~abort;
    assign phase_last = (state_q == LOAD_CLB) ? CW'(CLB_BITS - 1) : CW'(CONN_BITS - 1);
    assign last_bit   = (bit_cnt_q == phase_last);
    assign sample     = (state_q == LOAD_CLB) ? clb_scan_out : conn_scan_out;

    // Bits left in the current phase cap how many bits of a new byte are used.
    always_comb begin
        int rem;
        rem        = ((state_q == LOAD_CLB) ? CLB_BITS : CONN_BITS) - int'(bit_cnt_q);
        buf_fill_d = (rem >= BYTE_W) ? 4'(BYTE_W) : 4'(rem);
    end

    // Readback byte with the newly sampled bit placed at its LSB-first slot.
    always_comb begin
        rd_sh_d           = rd_sh_q;
        rd_sh_d[rd_cnt_q] = sample;
    end

    scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .run_i       (run),
        .scan_clk_o  (scan_clk),
        .rise_next_o (rise_next),
        .fall_next_o (fall_next)
    );

    // Phase FSM with byte intake, bit shifting and readback packing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            buf_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            rd_sh_q    <= '0;
            rd_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            captured_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (abort) begin
                state_q    <= IDLE;
                buf_q      <= '0;
                buf_cnt_q  <= '0;
                bit_cnt_q  <= '0;
                rd_sh_q    <= '0;
                rd_cnt_q   <= '0;
                captured_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start) state_q <= LOAD_CLB;
                    LOAD_CLB, LOAD_CONN: begin
                        if (accept) begin
                            buf_q     <= cfg_data;
                            buf_cnt_q <= buf_fill_d;
                        end
                        if (rise_next) captured_q <= 1'b1;
                        if (shift) begin
                            captured_q <= 1'b0;
                            buf_q      <= buf_q >> 1;
                            buf_cnt_q  <= buf_cnt_q - 4'd1;
                            if (rd_cnt_q == 3'd7 || last_bit) begin
                                rd_data_q  <= rd_sh_d;
                                rd_valid_q <= 1'b1;
                                rd_sh_q    <= '0;
                                rd_cnt_q   <= '0;
                            end else begin
                                rd_sh_q  <= rd_sh_d;
                                rd_cnt_q <= rd_cnt_q + 3'd1;
                            end
                            if (last_bit) begin
                                bit_cnt_q <= '0;
                                buf_q     <= '0;
                                buf_cnt_q <= '0;
                                state_q   <= (state_q == LOAD_CLB) ? LOAD_CONN : DONE;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CW'(1);
                            end
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign clb_scan_en  = (state_q == LOAD_CLB);
    assign conn_scan_en = (state_q == LOAD_CONN);
    assign clb_scan_in  = clb_scan_en & buf_q[0];
    assign conn_scan_in = conn_scan_en & buf_q[0];
    assign busy         = in_load;
    assign done         = (state_q == DONE);
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader with small chain models and a readback scoreboard.
module tb_fpga_cfg_loader;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready, scan_clk, clb_scan_en, clb_scan_in, clb_scan_out;
    logic       conn_scan_en, conn_scan_in, conn_scan_out, rd_valid, busy, done;
    logic [7:0] rd_data;

    int   vectors = 0, miscompares = 0, rise_cnt = 0, done_cnt = 0;
    logic sclk_prev = 1'b0;
    logic [7:0] exp_q[$];

    // Chain models: fabric shifts on scan_clk rise; scan_out is the displaced bit.
    logic [11:0] clb_chain, clb_pl = 12'h000;
    logic [7:0]  conn_chain, conn_pl = 8'h00;
    logic        clb_out_q, conn_out_q, pl_go = 1'b0;

    always @(posedge scan_clk or posedge pl_go) begin
        if (pl_go) begin
            clb_chain <= clb_pl;  clb_out_q  <= 1'b0;
            conn_chain <= conn_pl; conn_out_q <= 1'b0;
        end else begin
            if (clb_scan_en) begin
                clb_out_q <= clb_chain[0];
                clb_chain <= {clb_scan_in, clb_chain[11:1]};
            end
            if (conn_scan_en) begin
                conn_out_q <= conn_chain[0];
                conn_chain <= {conn_scan_in, conn_chain[7:1]};
            end
        end
    end
    assign clb_scan_out  = clb_out_q;
    assign conn_scan_out = conn_out_q;

    always #5 clk = ~clk;

    fpga_cfg_loader #(.CLB_BITS(12), .CONN_BITS(8), .CLK_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .scan_clk(scan_clk), .clb_scan_en(clb_scan_en), .clb_scan_in(clb_scan_in),
        .clb_scan_out(clb_scan_out), .conn_scan_en(conn_scan_en),
        .conn_scan_in(conn_scan_in), .conn_scan_out(conn_scan_out),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done)
    );

    function automatic logic [16:0] outs();
        return {cfg_ready, scan_clk, clb_scan_en, clb_scan_in, conn_scan_en,
                conn_scan_in, rd_valid, busy, done, rd_data};
    endfunction

    // Advance to the next falling clk edge; drain readback into the scoreboard.
    task automatic cyc();
        logic [7:0] e;
        @(negedge clk);
        if (rd_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected got=%h want=none", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    miscompares++;
                    $display("FAIL rd_data got=%h want=%h", rd_data, e);
                end
            end
        end
        if (done === 1'b1) done_cnt++;
        if (scan_clk === 1'b1 && sclk_prev === 1'b0) rise_cnt++;
        sclk_prev = scan_clk;
        if (clb_scan_en === 1'b1 && conn_scan_en === 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL both_enables got=11 want=not both");
        end
    endtask

    task automatic preload(input logic [11:0] c, input logic [7:0] n);
        clb_pl = c; conn_pl = n;
        pl_go = 1'b1; #1; pl_go = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
        vectors++;
        if (cfg_ready !== 1'b1) begin
            miscompares++; $display("FAIL start_ready got=%b want=1", cfg_ready);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        cfg_valid = 1'b1; cfg_data = b;
        for (int i = 0; i < 100; i++) begin
            if (cfg_ready === 1'b1) begin ok = 1'b1; cyc(); break; end
            cyc();
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL byte_accept got=timeout want=accept data=%h", b); end
    endtask

    // Full load of A5,0C,3C with readback and end-state checks.
    task automatic load_and_check(input string tag, input logic [11:0] cpre,
                                  input logic [7:0] npre, input bit stall, input bit start_mid);
        int r0, d0, errs;
        bit seen;
        logic prev_busy;
        logic [11:0] snap;
        preload(cpre, npre);
        exp_q.push_back(cpre[7:0]);
        exp_q.push_back({4'h0, cpre[11:8]});
        exp_q.push_back(npre);
        r0 = rise_cnt; d0 = done_cnt;
        do_start();
        send_byte(8'hA5);
        if (stall) cfg_valid = 1'b0; else cfg_data = 8'h0C;
        vectors++;
        if (scan_clk !== 1'b0) begin miscompares++; $display("FAIL %s first_rise_early got=%b want=0", tag, scan_clk); end
        cyc();
        vectors++;
        if (scan_clk !== 1'b1) begin miscompares++; $display("FAIL %s first_rise got=%b want=1", tag, scan_clk); end
        if (start_mid) begin start = 1'b1; cyc(); start = 1'b0; end
        if (stall) begin
            for (int i = 0; i < 50 && cfg_ready !== 1'b1; i++) cyc();
            snap = clb_chain; errs = 0;
            for (int i = 0; i < 10; i++) begin
                cyc();
                if (scan_clk !== 1'b0 || clb_scan_en !== 1'b1 || clb_chain !== snap || cfg_ready !== 1'b1) errs++;
            end
            vectors++;
            if (errs != 0) begin miscompares++; $display("FAIL %s stall_hold got=%0d bad cycles want=0", tag, errs); end
        end
        send_byte(8'h0C);
        send_byte(8'h3C);
        cfg_valid = 1'b0;
        seen = 1'b0; prev_busy = busy;
        for (int i = 0; i < 200; i++) begin
            prev_busy = busy; cyc();
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen || busy !== 1'b0 || prev_busy !== 1'b1) begin
            miscompares++; $display("FAIL %s done_busy got=seen%b busy%b prev%b want=seen1 busy0 prev1", tag, seen, busy, prev_busy);
        end
        cyc(); cyc();
        vectors++;
        if (clb_chain !== 12'hCA5) begin miscompares++; $display("FAIL %s clb_chain got=%h want=ca5", tag, clb_chain); end
        vectors++;
        if (conn_chain !== 8'h3C) begin miscompares++; $display("FAIL %s conn_chain got=%h want=3c", tag, conn_chain); end
        vectors++;
        if (rise_cnt - r0 != 20) begin miscompares++; $display("FAIL %s rises got=%0d want=20", tag, rise_cnt - r0); end
        vectors++;
        if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL %s done_pulses got=%0d want=1", tag, done_cnt - d0); end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL %s rd_missing got=%0d left want=0", tag, exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (outs() !== 17'h0) begin miscompares++; $display("FAIL reset_outs got=%h want=0", outs()); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cyc();
        vectors++;
        if (outs() !== 17'h0) begin miscompares++; $display("FAIL idle_outs got=%h want=0", outs()); end
    endtask

    task automatic test_basic_load();
        load_and_check("basic", 12'h000, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_readback();
        load_and_check("readback", 12'h5A3, 8'h81, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        load_and_check("stall", 12'h3C6, 8'hE7, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        int r0, d0;
        preload(12'h5A3, 8'h81);
        r0 = rise_cnt; d0 = done_cnt;
        do_start();
        cfg_valid = 1'b1; cfg_data = 8'hA5;
        for (int i = 0; i < 100 && rise_cnt - r0 < 5; i++) cyc();
        vectors++;
        if (rise_cnt - r0 != 5) begin miscompares++; $display("FAIL abort_reach got=%0d rises want=5", rise_cnt - r0); end
        abort = 1'b1; cyc(); abort = 1'b0; cfg_valid = 1'b0;
        vectors++;
        if ({busy, clb_scan_en, scan_clk, cfg_ready} !== 4'b0000) begin
            miscompares++; $display("FAIL abort_idle got=%b want=0000", {busy, clb_scan_en, scan_clk, cfg_ready});
        end
        for (int i = 0; i < 20; i++) cyc();
        vectors++;
        if (done_cnt != d0 || rise_cnt - r0 != 5) begin
            miscompares++; $display("FAIL abort_quiet got=done%0d rises%0d want=done0 rises5", done_cnt - d0, rise_cnt - r0);
        end
        load_and_check("after_abort", 12'h9E1, 8'h42, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int r0;
        preload(12'h5A3, 8'h81);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h05);
        r0 = rise_cnt;
        do_start();
        send_byte(8'hA5);
        send_byte(8'h0C);
        cfg_data = 8'h3C;
        for (int i = 0; i < 200 && !(conn_scan_en === 1'b1 && rise_cnt - r0 >= 15); i++) cyc();
        vectors++;
        if (conn_scan_en !== 1'b1) begin miscompares++; $display("FAIL rmid_phase got=%b want=1", conn_scan_en); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (outs() !== 17'h0) begin miscompares++; $display("FAIL rmid_async got=%h want=0", outs()); end
        cfg_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL rmid_rd got=%0d left want=0", exp_q.size()); exp_q.delete(); end
        load_and_check("after_reset", 12'h5A3, 8'h81, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        load_and_check("start_busy", 12'h1F0, 8'h0F, 1'b0, 1'b1);
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
            miscompares++; $display("FAIL abort_start got=busy%b ready%b want=busy0 ready0", busy, cfg_ready);
        end
        cyc(); cyc();
        vectors++;
        if (busy !== 1'b0 || clb_scan_en !== 1'b0) begin
            miscompares++; $display("FAIL abort_start_stay got=busy%b en%b want=00", busy, clb_scan_en);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_readback();
        test_stall();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Host-side driver for the fabric's two configuration scan chains: CLB chain first, then connection chain.
- Accepts configuration bytes over a valid/ready stream and serialises them LSB-first onto `clb_scan_in`, then `conn_scan_in`.
- Generates `scan_clk` and the scan enables, and returns the bits displaced from `clb_scan_out`/`conn_scan_out` as readback bytes.
- Sits between the configuration host interface and fpga_core.

Parameters:
- CLB_BITS, 4096: length of the CLB scan chain in bits.
- CONN_BITS, 2048: length of the connection scan chain in bits.
- CLK_DIV, 2: `clk` cycles per `scan_clk` half-period, ≥1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load; ignored unless IDLE.
- abort  input  1  one-cycle pulse; terminates a load, returns to IDLE.
- cfg_data  input  8  configuration byte, bit 0 shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  byte accepted when cfg_valid & cfg_ready.
- scan_clk  output  1  scan clock to fabric, registered.
- clb_scan_en  output  1  CLB chain shift enable.
- clb_scan_in  output  1  CLB chain serial data.
- clb_scan_out  input  1  CLB chain serial return.
- conn_scan_en  output  1  connection chain shift enable.
- conn_scan_in  output  1  connection chain serial data.
- conn_scan_out  input  1  connection chain serial return.
- rd_data  output  8  readback byte, first returned bit in bit 0.
- rd_valid  output  1  one-cycle strobe; no backpressure.
- busy  output  1  high in LOAD_CLB/LOAD_CONN.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the shift register, bit counter and readback byte are cleared.
- States: IDLE -> (start) LOAD_CLB -> (CLB_BITS bits shifted) LOAD_CONN -> (CONN_BITS bits shifted) DONE -> IDLE after 1 cycle.
  - done=1 in the DONE cycle only.
  - abort in any state -> IDLE next cycle. Enables and scan_clk go 0, and a partial readback byte is discarded.
  - abort and start in the same cycle: abort wins.
- Byte intake: an 8-bit shift buffer with a bit count.
  - cfg_ready=1 only when in a LOAD state and the buffer is empty.
  - Each phase consumes ceil(N/8) bytes. In a phase's final byte, bits above (N mod 8) are discarded and unused.
  - A new phase always starts on a fresh byte.
- Scan clock:
  - scan_clk toggles every CLK_DIV clk cycles, only while a bit is available.
  - If the buffer is empty, scan_clk holds low (stall, no error) until a byte arrives.
  - scan_clk is 0 in IDLE/DONE.
- Bit timing:
  - The data bit and enable are driven while scan_clk is low, at least CLK_DIV cycles before the rising edge.
  - The fabric captures on the rising edge.
  - The controller samples the scan_out of the active chain on the last clk cycle of the scan_clk high phase, then advances to the next bit at the falling transition.
- Enables:
  - clb_scan_en=1 throughout LOAD_CLB.
  - conn_scan_en=1 throughout LOAD_CONN.
  - Never both; each drops at the low phase after its final rising edge.
  - The idle serial data outputs are 0.
- Readback:
  - Sampled bits pack LSB-first.
  - rd_valid pulses for one cycle per 8 bits, or at phase end with a partial byte zero-padded in the upper bits.
  - Phases are never mixed in one byte.
- Counters: the bit counter is $clog2(max(CLB_BITS,CONN_BITS)+1) wide, with exact terminal compare; no wrap is possible.
- Latency: from start, cfg_ready rises the next cycle. The first scan_clk rise occurs CLK_DIV cycles after the first byte is accepted.

Decomposition:
- Package fpga_cfg_pkg holds:
  - the state enum (IDLE, LOAD_CLB, LOAD_CONN, DONE);
  - BYTE_W=8;
  - the CNT_W function.
- Sub-module scan_clk_gen holds the CLK_DIV counter, the run input, the scan_clk register, and the rise_next and fall_next strobes.
- The datapath and FSM live in fpga_cfg_loader.

Test Plan:
Benches use CLB_BITS=12, CONN_BITS=8 and CLK_DIV=1, with behavioural 12-bit and 8-bit chain models preloaded.
- Basic load:
  - Stimulus: start, then bytes 0xA5, 0x0C, 0x3C with valid held high.
  - Required: CLB chain = 0xCA5 (bits 0..11, upper nibble of 0x0C dropped); conn chain = 0x3C.
  - Required: 20 scan_clk rises total; done pulses once; busy falls together with done.
- Readback:
  - Stimulus: CLB model preloaded with 0x5A3, conn model with 0x81.
  - Required: rd_data sequence 0xA3, 0x05, 0x81, with three rd_valid pulses.
- Stall:
  - Stimulus: withhold the second byte for 10 cycles.
  - Required: scan_clk stays low, the enable stays high, and the chain contents are unchanged; shifting resumes and the final result is identical to the basic load.
- Abort:
  - Stimulus: abort after the 5th scan_clk rise.
  - Required: next cycle state=IDLE and clb_scan_en=0; no done and no further rd_valid.
  - Required: a new start then completes normally.
- Reset mid-load:
  - Stimulus: rst_n low during LOAD_CONN.
  - Required: all outputs are 0 immediately (asynchronous); after release, start is accepted.
- Start ignored:
  - Stimulus: start pulsed while busy, and abort+start in the same cycle.
  - Required: the load is unaffected in the first case; the block ends in IDLE in the second.
